// File: rtl/hazard_pkg.sv
// Shared types for the RAW-hazard scoreboard: entry layout, the register-file forwarding code,
// and the producer-availability helper.
package hazard_pkg;

    localparam int RA_W_MAX = 8;
    localparam int AVAIL_W  = 4;
    localparam int FWD_RF   = 0;

    // Register addresses are zero-extended to RA_W_MAX so one entry type serves every RA_W.
    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                we;
        logic [AVAIL_W-1:0]  avail;
    } sb_entry_t;

    // Stage index (1 = M) from which a producer's result can be forwarded.
    function automatic logic [AVAIL_W-1:0] calc_avail(input logic is_load, input int load_lat);
        calc_avail = is_load ? AVAIL_W'(1 + load_lat) : AVAIL_W'(1);
    endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Youngest-producer search for one source register: the lowest-index matching entry wins,
// and x0 never matches.
module fwd_prio_match
    import hazard_pkg::*;
#(
    parameter int NENT = 2,
    parameter int IW   = 1
) (
    input  logic [RA_W_MAX-1:0]  src_i,
    input  logic                 used_i,
    input  sb_entry_t [NENT-1:0] ent_i,
    output logic                 hit_o,
    output logic [IW-1:0]        idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = NENT - 1; k >= 0; k--) begin
            if (used_i && ent_i[k].valid && ent_i[k].we &&
                (ent_i[k].rd != '0) && (ent_i[k].rd == src_i)) begin
                hit_o = 1'b1;
                idx_o = IW'(k);
            end
        end
    end

endmodule

// File: rtl/riscv_fwd_scoreboard.sv
// RAW-hazard unit: tracks in-flight destinations from E to the last write-back stage and drives
// forwarding selects, F/D stalls and E bubbles. Define HAZARD_FWD_EN to enable forwarding.
module riscv_fwd_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int NSTAGES  = 2,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 5,
    parameter int FW       = $clog2(NSTAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_valid,
    input  logic [NSRC*RA_W-1:0] d_rs,
    input  logic [NSRC-1:0]      d_rs_used,
    input  logic [RA_W-1:0]      d_rd,
    input  logic                 d_reg_we,
    input  logic                 d_is_load,
    input  logic                 flush_d,
    input  logic                 hold,
    output logic                 stall_fd,
    output logic                 bubble_e,
    output logic [NSRC*FW-1:0]   fwd_sel
);

    sb_entry_t [NSTAGES:0] sb_q;
    sb_entry_t             e0_d;
    logic [AVAIL_W-1:0]    avail_ld;
    logic [NSRC-1:0]       st_hit;
    logic [NSRC*FW-1:0]    st_idx;
    logic [NSRC-1:0]       src_stall;
    logic                  stall_cond;

    always_comb begin
        avail_ld   = calc_avail(d_is_load, LOAD_LAT);
        e0_d       = '0;
        e0_d.valid = d_valid;
        e0_d.rd    = RA_W_MAX'(d_rd);
        e0_d.we    = d_reg_we;
`ifdef HAZARD_FWD_EN
        e0_d.avail = avail_ld;
`else
        // Without forwarding every producer is waited on until it retires.
        e0_d.avail = (avail_ld > AVAIL_W'(NSTAGES + 1)) ? avail_ld : AVAIL_W'(NSTAGES + 1);
`endif
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_stall
        fwd_prio_match #(.NENT(NSTAGES), .IW(FW)) u_match (
            .src_i (RA_W_MAX'(d_rs[i*RA_W +: RA_W])),
            .used_i(d_rs_used[i] & d_valid),
            .ent_i (sb_q[NSTAGES-1:0]),
            .hit_o (st_hit[i]),
            .idx_o (st_idx[i*FW +: FW])
        );
    end

    // Only the youngest producer decides; an older one behind it is shadowed.
    always_comb begin
        src_stall = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (st_hit[i] && ((int'(st_idx[i*FW +: FW]) + 1) <
                              int'(sb_q[st_idx[i*FW +: FW]].avail))) begin
                src_stall[i] = 1'b1;
            end
        end
    end

    assign stall_cond = |src_stall;
    assign stall_fd   = hold | (~flush_d & stall_cond);
    assign bubble_e   = ~hold & (flush_d | stall_cond);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else if (!hold) begin
            for (int k = 0; k < NSTAGES; k++) begin
                sb_q[k+1] <= sb_q[k];
            end
            sb_q[0] <= bubble_e ? sb_entry_t'('0) : e0_d;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [NSRC*RA_W-1:0] e0_rs_q;
    logic [NSRC-1:0]      e0_used_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_rs_q   <= '0;
            e0_used_q <= '0;
        end else if (!hold) begin
            e0_rs_q   <= d_rs;
            e0_used_q <= bubble_e ? '0 : (d_rs_used & {NSRC{d_valid}});
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        logic          hit;
        logic [FW-1:0] idx;

        fwd_prio_match #(.NENT(NSTAGES), .IW(FW)) u_match (
            .src_i (RA_W_MAX'(e0_rs_q[i*RA_W +: RA_W])),
            .used_i(e0_used_q[i] & sb_q[0].valid),
            .ent_i (sb_q[NSTAGES:1]),
            .hit_o (hit),
            .idx_o (idx)
        );

        assign fwd_sel[i*FW +: FW] = hit ? (idx + FW'(1)) : FW'(FWD_RF);
    end
`else
    assign fwd_sel = '0;
`endif

endmodule

// File: tb/tb_riscv_fwd_scoreboard.sv
// Bench for riscv_fwd_scoreboard (default parameters): directed RV32I hazard sequences; the driver
// queues the expected stall/bubble/fwd_sel for each cycle and a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_riscv_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_valid = 1'b0;
    logic [9:0] d_rs = '0;
    logic [1:0] d_rs_used = '0;
    logic [4:0] d_rd = '0;
    logic       d_reg_we = 1'b0;
    logic       d_is_load = 1'b0;
    logic       flush_d = 1'b0;
    logic       hold = 1'b0;
    logic       stall_fd;
    logic       bubble_e;
    logic [3:0] fwd_sel;

    typedef struct {
        string      tag;
        logic       s;
        logic       b;
        logic [3:0] f;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_fwd_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .d_valid  (d_valid),
        .d_rs     (d_rs),
        .d_rs_used(d_rs_used),
        .d_rd     (d_rd),
        .d_reg_we (d_reg_we),
        .d_is_load(d_is_load),
        .flush_d  (flush_d),
        .hold     (hold),
        .stall_fd (stall_fd),
        .bubble_e (bubble_e),
        .fwd_sel  (fwd_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_eq({mon_e.tag, ".stall_fd"}, int'(stall_fd), int'(mon_e.s));
            check_eq({mon_e.tag, ".bubble_e"}, int'(bubble_e), int'(mon_e.b));
            check_eq({mon_e.tag, ".fwd_sel"},  int'(fwd_sel),  int'(mon_e.f));
        end
    end

    task automatic cyc(input string tag, input logic v, input logic [4:0] rd, rs1, rs2,
                       input logic [1:0] used, input logic ld, fl, hd, rs,
                       input logic es, eb, input logic [3:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        d_valid   = v;
        d_rd      = rd;
        d_rs      = {rs2, rs1};
        d_rs_used = used;
        d_reg_we  = v;
        d_is_load = ld;
        flush_d   = fl;
        hold      = hd;
        rst       = rs;
        e.tag = tag;
        e.s   = es;
        e.b   = eb;
        e.f   = ef;
        exp_q.push_back(e);
    endtask

    task automatic op(input string tag, input logic [4:0] rd, rs1, rs2, input logic [1:0] used,
                      input logic ld, input logic es, eb, input logic [3:0] ef);
        cyc(tag, 1'b1, rd, rs1, rs2, used, ld, 1'b0, 1'b0, 1'b0, es, eb, ef);
    endtask

    task automatic nop(input string tag, input logic es, eb, input logic [3:0] ef);
        cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, es, eb, ef);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) nop(tag, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        nop("reset", 0, 0, 4'h0);

        // add x8,x4,x5 ; sub x2,x8,x3
        op("A.add", 8, 4, 5, 2'b11, 0, 0, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("A.sub", 2, 8, 3, 2'b11, 0, 0, 0, 4'h0);
        nop("A.fwd", 0, 0, 4'b0001);
`else
        op("A.sub_st0", 2, 8, 3, 2'b11, 0, 1, 1, 4'h0);
        op("A.sub_st1", 2, 8, 3, 2'b11, 0, 1, 1, 4'h0);
        op("A.sub_go",  2, 8, 3, 2'b11, 0, 0, 0, 4'h0);
`endif
        drain("A.drain");

        // add x1,x2,x3 ; add x1,x3,x4 ; add x5,x2,x1  (M copy of x1 beats W copy)
        op("B.i1", 1, 2, 3, 2'b11, 0, 0, 0, 4'h0);
        op("B.i2", 1, 3, 4, 2'b11, 0, 0, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("B.i3", 5, 2, 1, 2'b11, 0, 0, 0, 4'h0);
        nop("B.fwd_rs2", 0, 0, 4'b0100);
`else
        op("B.i3_st0", 5, 2, 1, 2'b11, 0, 1, 1, 4'h0);
        op("B.i3_st1", 5, 2, 1, 2'b11, 0, 1, 1, 4'h0);
        op("B.i3_go",  5, 2, 1, 2'b11, 0, 0, 0, 4'h0);
`endif
        drain("B.drain");

        // same with x1 as rs1
        op("B2.i1", 1, 2, 3, 2'b11, 0, 0, 0, 4'h0);
        op("B2.i2", 1, 3, 4, 2'b11, 0, 0, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("B2.i3", 5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
        nop("B2.fwd_rs1", 0, 0, 4'b0001);
`else
        op("B2.i3_st0", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("B2.i3_st1", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("B2.i3_go",  5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
`endif
        drain("B2.drain");

        // lw x1,0(x0) ; add x5,x1,x2
        op("C.lw", 1, 0, 0, 2'b01, 1, 0, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("C.add_st", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("C.add_go", 5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
        nop("C.fwd_ld", 0, 0, 4'b0010);
`else
        op("C.add_st0", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("C.add_st1", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("C.add_go",  5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
`endif
        drain("C.drain");

        // add x0,x4,x5 ; add x6,x0,x0 -- x0 is never a producer
        op("D.wr_x0", 0, 4, 5, 2'b11, 0, 0, 0, 4'h0);
        op("D.rd_x0", 6, 0, 0, 2'b11, 0, 0, 0, 4'h0);
        drain("D.drain");

        // load-use stall coincident with a flush
        op("E.lw", 1, 0, 0, 2'b01, 1, 0, 0, 4'h0);
        cyc("E.flush", 1, 5, 1, 2, 2'b11, 0, 1, 0, 0, 0, 1, 4'h0);
        drain("E.drain");

        // hold during a load-use stall freezes the scoreboard
        op("F.lw", 1, 0, 0, 2'b01, 1, 0, 0, 4'h0);
        cyc("F.hold", 1, 5, 1, 2, 2'b11, 0, 0, 1, 0, 1, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("F.add_st", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("F.add_go", 5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
        nop("F.fwd_ld", 0, 0, 4'b0010);
`else
        op("F.add_st0", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("F.add_st1", 5, 1, 2, 2'b11, 0, 1, 1, 4'h0);
        op("F.add_go",  5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
`endif
        drain("F.drain");

        // reset in the middle of a stall
        op("G.lw", 1, 0, 0, 2'b01, 1, 0, 0, 4'h0);
        cyc("G.rst", 1, 5, 1, 2, 2'b11, 0, 0, 0, 1, 1, 1, 4'h0);
        op("G.after", 5, 1, 2, 2'b11, 0, 0, 0, 4'h0);
        drain("G.drain");

        // ALU producer two stages ahead: forwarded from W
        op("H.i1", 7, 3, 4, 2'b11, 0, 0, 0, 4'h0);
        nop("H.gap", 0, 0, 4'h0);
`ifdef HAZARD_FWD_EN
        op("H.i3", 9, 7, 0, 2'b01, 0, 0, 0, 4'h0);
        nop("H.fwd_w", 0, 0, 4'b0010);
`else
        op("H.i3_st", 9, 7, 0, 2'b01, 0, 1, 1, 4'h0);
        op("H.i3_go", 9, 7, 0, 2'b01, 0, 0, 0, 4'h0);
`endif
        drain("H.drain");

        // operands not read never hazard or forward
        op("I.i1", 10, 1, 2, 2'b11, 1, 0, 0, 4'h0);
        op("I.unused", 11, 10, 10, 2'b00, 0, 0, 0, 4'h0);
        nop("I.nofwd", 0, 0, 4'h0);
        drain("I.drain");

        // invalid D slot never stalls
        op("J.lw", 12, 0, 0, 2'b01, 1, 0, 0, 4'h0);
        cyc("J.invalid", 0, 0, 12, 12, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0);
        drain("J.drain");

        hold = 1'b0;
        repeat (2) @(posedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
